// File: rtl/metronome_pkg.sv
// Shared types and constants for the metronome tempo path (BPM width is common with the incrementer).
package metronome_pkg;

    localparam int BPM_W = 8;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        START   = 2'd1,
        RUN     = 2'd2
    } state_e;

    // One beat costs CLK_HZ*60 accumulator units; each cycle adds the BPM value.
    function automatic logic [63:0] thresh(input logic [63:0] clk_hz);
        return clk_hz * 64'd60;
    endfunction

endpackage

// File: rtl/click_stretcher.sv
// Retriggerable pulse stretcher: each trigger (re)loads CYCLES; output is high while the count is non-zero.
module click_stretcher #(
    parameter int CYCLES = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic trig_i,
    output logic out_o
);

    localparam int CNT_W = $clog2(CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (trig_i) begin
            cnt_d = CNT_W'(CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_o = (cnt_q != '0);

endmodule

// File: rtl/metronome_beat_gen.sv
// Phase-accumulator metronome: BEAT every CLK_HZ*60/BPM cycles, bar ACCENT, stretched CLICK.
// Bar counter / accent logic is built only when METRO_ACCENT_EN is defined.
module metronome_beat_gen
    import metronome_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int ACC_W    = 32,
    parameter int BPM_MIN  = 30,
    parameter int BPM_MAX  = 250,
    parameter int CLICK_MS = 20
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic [BPM_W-1:0] bpm_i,
    input  logic [2:0]       beats_per_bar_i,
    output logic             beat_o,
    output logic             accent_o,
    output logic [2:0]       beat_cnt_o,
    output logic             click_o,
    output state_e           state_o
);

    localparam logic [63:0]      THRESH    = thresh(64'(CLK_HZ));
    localparam logic [ACC_W-1:0] THRESH_A  = THRESH[ACC_W-1:0];
    localparam int               CLICK_RAW = CLK_HZ / 1000 * CLICK_MS;
    localparam int               CLICK_CYC = (CLICK_RAW < 1) ? 1 : CLICK_RAW;
    localparam logic [BPM_W-1:0] BPM_LO    = BPM_W'(BPM_MIN);
    localparam logic [BPM_W-1:0] BPM_HI    = BPM_W'(BPM_MAX);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
    logic             beat_q, beat_d;
    logic [BPM_W-1:0] bpm_eff;
    logic             hit;
    logic             click_raw;

    always_comb begin
        bpm_eff = bpm_i;
        if (bpm_i < BPM_LO) begin
            bpm_eff = BPM_LO;
        end else if (bpm_i > BPM_HI) begin
            bpm_eff = BPM_HI;
        end
    end

    assign acc_sum = acc_q + {{(ACC_W-BPM_W){1'b0}}, bpm_eff};
    assign hit     = (acc_sum >= THRESH_A);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        beat_d  = 1'b0;
        case (state_q)
            STOPPED: begin
                acc_d = '0;
                if (enable_i) state_d = START;
            end
            START: begin
                acc_d   = '0;
                beat_d  = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (hit) begin
                    acc_d  = acc_sum - THRESH_A;
                    beat_d = 1'b1;
                end else begin
                    acc_d = acc_sum;
                end
            end
            default: state_d = STOPPED;
        endcase
        // Dropping ENABLE overrides everything, including a beat due this cycle.
        if (!enable_i) begin
            state_d = STOPPED;
            acc_d   = '0;
            beat_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= STOPPED;
            acc_q   <= '0;
            beat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            beat_q  <= beat_d;
        end
    end

`ifdef METRO_ACCENT_EN
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] cnt_inc;
    logic       accent_q, accent_d;

    always_comb begin
        cnt_inc = {1'b0, cnt_q} + 4'd1;
        cnt_d   = cnt_q;
        if (!enable_i || state_q != RUN) begin
            cnt_d = 3'd0;
        end else if (hit) begin
            // Compare against the live bar length so a shortened bar wraps instead of overrunning.
            cnt_d = (cnt_inc >= {1'b0, beats_per_bar_i}) ? 3'd0 : cnt_inc[2:0];
        end
        accent_d = beat_d && (cnt_d == 3'd0) && (beats_per_bar_i != 3'd0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= 3'd0;
            accent_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            accent_q <= accent_d;
        end
    end

    assign beat_cnt_o = cnt_q;
    assign accent_o   = accent_q;
`else
    logic unused_bpb;
    assign unused_bpb = ^beats_per_bar_i;
    assign beat_cnt_o = 3'd0;
    assign accent_o   = 1'b0;
`endif

    // Triggered by the next-state beat so CLICK rises in the same cycle as BEAT.
    click_stretcher #(
        .CYCLES(CLICK_CYC)
    ) u_click (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .trig_i(beat_d),
        .out_o (click_raw)
    );

    assign click_o = click_raw && enable_i && (state_q == RUN);
    assign beat_o  = beat_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_metronome_beat_gen.sv
// Bench for metronome_beat_gen (CLK_HZ=1000, CLICK_MS=5): directed tempo scenarios plus random tempo/enable churn.
module tb_metronome_beat_gen;
    import metronome_pkg::*;

    localparam int     CLICK_CYC = 5;
    localparam longint THRESH    = 60000;
`ifdef METRO_ACCENT_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] bpm = 8'd60;
    logic [2:0] bpb = 3'd4;
    logic       beat, accent, click;
    logic [2:0] cnt;
    state_e     state;

    always #5 clk = ~clk;

    metronome_beat_gen #(
        .CLK_HZ(1000), .ACC_W(32), .BPM_MIN(30), .BPM_MAX(250), .CLICK_MS(5)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .bpm_i(bpm),
        .beats_per_bar_i(bpb), .beat_o(beat), .accent_o(accent),
        .beat_cnt_o(cnt), .click_o(click), .state_o(state)
    );

    int vectors = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    // en_cyc: edges ENABLE has been continuously high (saturating at 3 = running).
    int     en_cyc = 0;
    longint phase = 0;
    bit     m_beat = 0, m_accent = 0;
    int     m_cnt = 0, m_left = 0;

    function automatic int eff(input logic [7:0] b);
        if (b < 30) return 30;
        if (b > 250) return 250;
        return int'(b);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_cyc = 0; phase = 0; m_beat = 0; m_accent = 0; m_cnt = 0; m_left = 0;
        end else begin
            m_beat = 0;
            if (!enable) begin
                en_cyc = 0; phase = 0; m_cnt = 0;
            end else begin
                if (en_cyc < 3) en_cyc++;
                if (en_cyc == 2) begin
                    m_beat = 1; phase = 0; m_cnt = 0;
                end else if (en_cyc == 3) begin
                    phase += eff(bpm);
                    if (phase >= THRESH) begin
                        phase -= THRESH;
                        m_beat = 1;
                        m_cnt = (m_cnt + 1 >= int'(bpb)) ? 0 : m_cnt + 1;
                    end
                end
            end
            if (!ACC_EN) m_cnt = 0;
            m_accent = ACC_EN && m_beat && (m_cnt == 0) && (bpb != 3'd0);
            m_left = m_beat ? CLICK_CYC : ((m_left > 0) ? m_left - 1 : 0);
        end
    end

    // ---------------- scoreboard monitor (negedge + 2) ----------------
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            vectors += 4;
            if (beat !== m_beat) begin
                miscompares++; $display("FAIL mon_beat t=%0t got %0b exp %0b", $time, beat, m_beat);
            end
            if (accent !== m_accent) begin
                miscompares++; $display("FAIL mon_accent t=%0t got %0b exp %0b", $time, accent, m_accent);
            end
            if (cnt !== 3'(m_cnt)) begin
                miscompares++; $display("FAIL mon_cnt t=%0t got %0d exp %0d", $time, cnt, m_cnt);
            end
            if (click !== (m_left != 0 && enable && en_cyc >= 2)) begin
                miscompares++; $display("FAIL mon_click t=%0t got %0b", $time, click);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic restart();
        enable = 1'b0; step(1); enable = 1'b1;
    endtask

    // Cycles until the next BEAT is seen; -1 if the budget runs out.
    task automatic wait_beat(input int budget, output int n);
        n = 0;
        do begin step(1); n++; end while (!beat && n < budget);
        if (!beat) n = -1;
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++; $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n;
        rst_n = 1'b0; enable = 1'b1; bpm = 8'd60; bpb = 3'd4;
        step(3);
        vectors += 5;
        if (beat !== 1'b0)   begin miscompares++; $display("FAIL rst_beat got %0b exp 0", beat); end
        if (accent !== 1'b0) begin miscompares++; $display("FAIL rst_accent got %0b exp 0", accent); end
        if (cnt !== 3'd0)    begin miscompares++; $display("FAIL rst_cnt got %0d exp 0", cnt); end
        if (click !== 1'b0)  begin miscompares++; $display("FAIL rst_click got %0b exp 0", click); end
        if (state !== STOPPED) begin miscompares++; $display("FAIL rst_state got %0d exp 0", state); end
        rst_n = 1'b1;
        wait_beat(10, n);
        chk_int("first_beat_latency", n, 2);
        chk_int("first_accent", int'(accent), int'(ACC_EN));
        wait_beat(1500, n);
        chk_int("spacing_60bpm", n, 1000);
    endtask

    task automatic test_tempo_bar();
        int n, hi;
        bpm = 8'd120; bpb = 3'd4;
        restart();
        wait_beat(10, n);
        chk_int("t2_start_latency", n, 2);
        for (int k = 1; k <= 5; k++) begin
            wait_beat(800, n);
            chk_int("t2_spacing_120", n, 500);
            chk_int("t2_cnt", int'(cnt), ACC_EN ? (k % 4) : 0);
            chk_int("t2_accent", int'(accent), (ACC_EN && (k % 4 == 0)) ? 1 : 0);
        end
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            if (click) hi++;
            step(1);
        end
        chk_int("t2_click_width", hi, CLICK_CYC);
    endtask

    task automatic test_clamp();
        int n;
        bpm = 8'd10; restart();
        wait_beat(10, n);
        wait_beat(2500, n);
        chk_int("clamp_low_spacing", n, 2000);
        bpm = 8'd255; restart();
        wait_beat(10, n);
        wait_beat(400, n);
        chk_int("clamp_high_spacing", n, 240);
        wait_beat(400, n);
        chk_int("clamp_high_spacing2", n, 240);
    endtask

    task automatic test_bpm_change();
        int n;
        bpm = 8'd60; restart();
        wait_beat(10, n);
        step(400);
        bpm = 8'd120;
        wait_beat(1000, n);
        chk_int("bpm_change_next_beat", n, 300);
    endtask

    task automatic test_enable_drop();
        int n, beats;
        bpm = 8'd120; bpb = 3'd4; restart();
        wait_beat(10, n);
        wait_beat(800, n);
        step(2);
        enable = 1'b0;
        step(1);
        chk_int("drop_click", int'(click), 0);
        chk_int("drop_state", int'(state), int'(STOPPED));
        beats = 0;
        for (int i = 0; i < 700; i++) begin step(1); if (beat) beats++; end
        chk_int("drop_no_beats", beats, 0);
        enable = 1'b1;
        wait_beat(10, n);
        chk_int("reenable_latency", n, 2);
        chk_int("reenable_cnt", int'(cnt), 0);
        chk_int("reenable_accent", int'(accent), int'(ACC_EN));
    endtask

    task automatic test_bar_length();
        int n, acc_seen;
        bpm = 8'd250; bpb = 3'd0; restart();
        acc_seen = 0;
        for (int k = 0; k < 6; k++) begin
            wait_beat(400, n);
            if (accent) acc_seen++;
        end
        chk_int("bpb0_no_accent", acc_seen, 0);
        bpb = 3'd4; restart();
        wait_beat(10, n);
        for (int k = 0; k < 3; k++) wait_beat(400, n);
        chk_int("bpb4_reach3", int'(cnt), ACC_EN ? 3 : 0);
        bpb = 3'd2;
        wait_beat(400, n);
        chk_int("bpb_shrink_wrap", int'(cnt), 0);
        chk_int("bpb_shrink_accent", int'(accent), int'(ACC_EN));
        wait_beat(400, n);
        chk_int("bpb2_next", int'(cnt), ACC_EN ? 1 : 0);
    endtask

    task automatic test_async_reset();
        int n;
        bpm = 8'd250; bpb = 3'd3; restart();
        wait_beat(10, n);
        wait_beat(400, n);
        #2 rst_n = 1'b0;
        #1;
        vectors += 2;
        if (click !== 1'b0) begin miscompares++; $display("FAIL arst_click got %0b exp 0", click); end
        if (beat !== 1'b0)  begin miscompares++; $display("FAIL arst_beat got %0b exp 0", beat); end
        step(2);
        rst_n = 1'b1;
        wait_beat(10, n);
        chk_int("arst_restart_latency", n, 2);
    endtask

    task automatic test_random();
        bpm = 8'd200; bpb = 3'd4; enable = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 99) < 2) bpm = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 199) < 1) bpb = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 299) < 1) enable = ~enable;
            if (!enable && $urandom_range(0, 9) < 3) enable = 1'b1;
            step(1);
        end
        enable = 1'b1;
        step(5);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tempo_bar();
        test_clamp();
        test_bpm_change();
        test_enable_drop();
        test_bar_length();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
